// File: rtl/m6502_bus_responder.sv
// m6502_bus_responder: memory-side responder for the M6502 core bus.
// Owns the program ROM, the mirrored work RAM and a result mailbox.
// Runs a ROM load phase, holds the CPU in reset for a fixed number of cycles,
// then serves CPU bus cycles until the program writes the mailbox.
//
// Loader handshake: a byte moves on a rising clock edge where i_ld_valid and
// o_ld_ready are both high. The loader may hold i_ld_valid low for any number
// of cycles, and o_ld_ready drops on the same edge that accepts the final byte.
module m6502_bus_responder #(
    parameter int          RAM_AW       = 11,
    parameter int          ROM_AW       = 15,
    parameter logic [15:0] MAILBOX_ADDR = 16'h6000,
    parameter int          RST_HOLD     = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic        i_rw,
    inout  wire  [7:0]  io_data,
    output logic        o_cpu_rst,
    input  logic        i_ld_valid,
    input  logic [7:0]  i_ld_data,
    input  logic        i_ld_last,
    output logic        o_ld_ready,
    output logic        o_halted,
    output logic        o_pass,
    output logic [7:0]  o_code,
    output logic        o_rom_wr_err,
    output logic [31:0] o_cycles,
    output logic [1:0]  o_dbg_state
);

    localparam int HOLD_W    = $clog2(RST_HOLD + 1);
    localparam int RAM_DEPTH = 1 << RAM_AW;
    localparam int ROM_DEPTH = 1 << ROM_AW;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t            state;
    logic [ROM_AW-1:0] ld_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [7:0]        bus_q;     // open-bus latch, also the registered read data
    logic              drive_en;  // a read address was sampled on the previous edge

    logic [7:0] ram [RAM_DEPTH];
    logic [7:0] rom [ROM_DEPTH];

    logic       is_mbox;
    logic       is_ram;
    logic       is_rom;
    logic       ld_fire;
    logic       run_wr;
    logic [7:0] rd_val;

    assign o_dbg_state = state;

    // Drive the CPU bus only during a run-state read, one cycle after sampling.
    assign io_data = (drive_en && (state == ST_RUN) && i_rw) ? bus_q : 8'hzz;

    // Address decode in priority order: mailbox, RAM, ROM, otherwise unmapped.
    always_comb begin
        is_mbox = (i_addr == MAILBOX_ADDR);
        is_ram  = 1'b0;
        is_rom  = 1'b0;
        if (!is_mbox) begin
            is_ram = (i_addr < 16'h2000);
            is_rom = (i_addr >= 16'h8000);
        end
    end

    // Qualified transfer strobes for the loader and CPU write cycles.
    always_comb begin
        ld_fire = (state == ST_LOAD) && i_ld_valid && o_ld_ready;
        run_wr  = (state == ST_RUN) && !i_rw;
    end

    // Read value for the current address; unmapped and mailbox reads see open bus.
    always_comb begin
        rd_val = bus_q;
        if (is_ram) begin
            rd_val = ram[i_addr[RAM_AW-1:0]];
        end else if (is_rom) begin
            rd_val = rom[i_addr[ROM_AW-1:0]];
        end
    end

    // Memory arrays keep their contents across reset.
    always_ff @(posedge i_clk) begin
        if (ld_fire) begin
            rom[ld_cnt] <= i_ld_data;
        end
        if (run_wr && is_ram) begin
            ram[i_addr[RAM_AW-1:0]] <= io_data;
        end
    end

    // Phase sequencer: load, hold CPU in reset, serve bus cycles, halt on mailbox.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= ST_LOAD;
            ld_cnt       <= '0;
            hold_cnt     <= '0;
            bus_q        <= 8'h00;
            drive_en     <= 1'b0;
            o_cpu_rst    <= 1'b0;
            o_ld_ready   <= 1'b0;
            o_halted     <= 1'b0;
            o_pass       <= 1'b0;
            o_code       <= 8'h00;
            o_rom_wr_err <= 1'b0;
            o_cycles     <= 32'd0;
        end else begin
            drive_en <= 1'b0;
            case (state)
                ST_LOAD: begin
                    o_ld_ready <= 1'b1;
                    if (ld_fire) begin
                        // The counter stops at the top of ROM instead of wrapping.
                        if (!(&ld_cnt)) begin
                            ld_cnt <= ld_cnt + ROM_AW'(1);
                        end
                        if (i_ld_last || (&ld_cnt)) begin
                            state      <= ST_HOLD;
                            o_ld_ready <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                        state     <= ST_RUN;
                        o_cpu_rst <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (o_cycles != 32'hFFFF_FFFF) begin
                        o_cycles <= o_cycles + 32'd1;
                    end
                    if (i_rw) begin
                        bus_q    <= rd_val;
                        drive_en <= 1'b1;
                    end else begin
                        // Every write leaves its byte on the open bus.
                        bus_q <= io_data;
                        if (is_mbox) begin
                            o_code    <= io_data;
                            o_pass    <= (io_data == 8'h00);
                            o_halted  <= 1'b1;
                            o_cpu_rst <= 1'b0;
                            state     <= ST_HALT;
                        end else if (is_rom) begin
                            o_rom_wr_err <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    o_cpu_rst <= 1'b0;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/m6502_bus_responder.md
Name: m6502_bus_responder

Overview:
- Memory-side responder for the M6502 core bus: owns the RAM, ROM and a test mailbox, and serves the CPU's o_addr/o_rw/io_data.
- Sequences a ROM load phase and holds the CPU in reset until loading completes.
- In run, decodes every bus cycle and halts when the program writes a result to the mailbox.
- Reusable from benches and from the board top in place of ad-hoc memory models.

Parameters:
- RAM_AW, 11: RAM address width; 2 KiB mirrored across 0x0000-0x1FFF.
- ROM_AW, 15: ROM address width; ROM occupies 0x8000-0xFFFF.
- MAILBOX_ADDR, 16'h6000: result mailbox address.
- RST_HOLD, 8: cycles the CPU reset stays asserted after load completes.

Ports:
- i_clk  in  1  clock; all state changes on its posedge.
- i_rst  in  1  asynchronous, active-low reset.
- i_addr  in  16  CPU address (from core o_addr).
- i_rw  in  1  CPU direction; 1 = read, 0 = write.
- io_data  inout  8  CPU data bus.
- o_cpu_rst  out  1  active-low reset to the core's i_rst.
- i_ld_valid  in  1  loader byte valid.
- i_ld_data  in  8  loader byte.
- i_ld_last  in  1  marks the final loader byte.
- o_ld_ready  out  1  responder accepts a loader byte.
- o_halted  out  1  mailbox written; program finished.
- o_pass  out  1  the mailbox value was 0x00.
- o_code  out  8  the mailbox value.
- o_rom_wr_err  out  1  sticky flag: the CPU wrote to the ROM region.
- o_cycles  out  32  count of run-state cycles.

Behaviour:
- Reset (i_rst=0, asynchronous) forces:
  - state LOAD, loader counter 0, hold counter 0;
  - o_cpu_rst=0, o_ld_ready=0, io_data high-Z;
  - o_halted=0, o_pass=0, o_code=0, o_rom_wr_err=0, o_cycles=0.
- RAM and ROM arrays are not cleared by reset.
- States: LOAD -> HOLD -> RUN -> HALT. HALT is left only by reset.
- LOAD:
  - o_ld_ready=1 from the first clock after reset release.
  - A byte transfers on a posedge with i_ld_valid & o_ld_ready. It is written to ROM[cnt], then cnt increments.
  - Transfer with i_ld_last=1 -> HOLD next cycle; o_ld_ready drops the same edge.
  - Transfer at cnt = 2^ROM_AW-1 -> HOLD regardless of i_ld_last; the counter does not wrap.
  - i_ld_valid=0 -> no change; the loader may stall indefinitely.
  - The CPU bus is ignored; o_cpu_rst stays 0.
- HOLD:
  - o_cpu_rst=0 for exactly RST_HOLD cycles, then RUN.
  - o_cpu_rst=1 is registered on the HOLD->RUN edge.
- RUN, address decode (priority order):
  1. i_addr == MAILBOX_ADDR: mailbox.
  2. i_addr < 0x2000: RAM[i_addr[RAM_AW-1:0]].
  3. i_addr >= 0x8000: ROM[i_addr[ROM_AW-1:0]].
  4. Anything else: unmapped.
- RUN, reads (i_rw=1):
  - Data is registered from the address sampled at posedge N and driven onto io_data during cycle N+1. One-cycle latency, matching the core's fetch timing.
  - Unmapped and mailbox reads return the open-bus value, i.e. the last byte driven or written. Reset value of open bus is 0x00.
- RUN, writes (i_rw=0):
  - io_data is high-Z, sampled at posedge.
  - RAM region: RAM written.
  - ROM region: ROM unchanged; o_rom_wr_err set (sticky).
  - Unmapped region: discarded; open bus updated.
- RUN, mailbox write:
  - o_code <= data; o_pass <= (data==0); o_halted <= 1; state HALT.
  - This takes priority over any other decode of the same address.
- o_cycles increments every RUN cycle, saturating at 0xFFFFFFFF. It freezes in HALT.
- HALT:
  - o_cpu_rst=0 (CPU held); io_data high-Z.
  - Status outputs hold until reset.
- io_data driver enable = (state==RUN) & i_rw, and only from the cycle after a read address is sampled. The responder never drives while i_rw=0.
- Reset mid-LOAD: counter restarts at 0; bytes already written persist but will be overwritten.
- Reset mid-RUN: the CPU is held again and the LOAD phase repeats.

Test Plan:
- Load 4 bytes A9,00,8D,60 with i_ld_last on byte 4, then pad via vectors -> ROM[0..3] match; o_ld_ready falls after byte 4; o_cpu_rst rises exactly 8 cycles after HOLD entry.
- Loader stalls 5 cycles mid-stream (i_ld_valid=0) -> no ROM writes; cnt unchanged; load completes correctly after resume.
- RUN: write 0x5A to 0x0010, read 0x0810 -> 0x5A appears on io_data one cycle after the address (mirroring); io_data high-Z during the write cycle.
- RUN: write 0x33 to 0x8000 -> ROM[0] unchanged; o_rom_wr_err=1 and stays 1; read of 0x4000 returns 0x33 (open bus).
- Mailbox write 0x00 -> o_halted=1, o_pass=1, o_code=0x00, o_cpu_rst=0, o_cycles frozen. Separate run with mailbox write 0x07 -> o_pass=0, o_code=0x07.
- Assert i_rst=0 mid-RUN, asynchronously between edges -> all outputs reach reset values immediately; state LOAD; o_ld_ready=1 one clock after release.
